// File: rtl/mem_pkg.sv
// Shared types and constants for the memi memory responder.
package mem_pkg;

   typedef enum logic {IDLE, RD_WAIT} mem_state_t;

   localparam int CNT_W      = 16;
   localparam int MAX_RD_LAT = 4;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// memi request/response bundle between a memory test initiator and the responder.
interface mem_responder_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) ();
   import mem_pkg::*;

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              ready;
   logic              rvalid;
   logic              err;
   logic [CNT_W-1:0]  rd_count;
   logic [CNT_W-1:0]  wr_count;

   modport memi_dut (
      input  read, write, addr, data_in,
      output data_out, ready, rvalid, err, rd_count, wr_count
   );

   modport memi_tb (
      output read, write, addr, data_in,
      input  data_out, ready, rvalid, err, rd_count, wr_count
   );

endinterface

// File: rtl/mem_array.sv
// Storage array: synchronous write, combinational read, async clear.
module mem_array #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; reset clears every location.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// memi responder: write/read acceptance, programmable read latency, access statistics.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_,
   mem_responder_if.memi_dut  bus
);
   localparam int LAT_W = $clog2(MAX_RD_LAT);

   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
      $error("mem_responder: RD_LAT=%0d outside 1..%0d", RD_LAT, MAX_RD_LAT);
   end

   mem_state_t        state;
   logic [LAT_W-1:0]  lat_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] rdata_c;
   logic              wr_acc_c;
   logic              rd_acc_c;
   logic              bad_c;

   // Requests only count while ready; both strobes together are rejected.
   assign wr_acc_c = bus.ready &  bus.write & ~bus.read;
   assign rd_acc_c = bus.ready &  bus.read  & ~bus.write;
   assign bad_c    = bus.ready &  bus.read  &  bus.write;

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .rst_  (rst_),
      .we    (wr_acc_c),
      .waddr (bus.addr),
      .wdata (bus.data_in),
      .raddr (addr_q),
      .rdata (rdata_c)
   );

   // Read FSM: latch address, count down latency, then return data with rvalid.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state        <= IDLE;
         lat_cnt      <= '0;
         addr_q       <= '0;
         bus.ready    <= 1'b1;
         bus.rvalid   <= 1'b0;
         bus.err      <= 1'b0;
         bus.data_out <= '0;
      end else begin
         bus.rvalid <= 1'b0;
         bus.err    <= bad_c;
         case (state)
            IDLE: begin
               if (rd_acc_c) begin
                  addr_q    <= bus.addr;
                  lat_cnt   <= LAT_W'(RD_LAT - 1);
                  bus.ready <= 1'b0;
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == '0) begin
                  bus.data_out <= rdata_c;
                  bus.rvalid   <= 1'b1;
                  bus.ready    <= 1'b1;
                  state        <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Saturating statistics of accepted reads and writes.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         bus.rd_count <= '0;
         bus.wr_count <= '0;
      end else begin
         if (rd_acc_c) bus.rd_count <= sat_inc(bus.rd_count);
         if (wr_acc_c) bus.wr_count <= sat_inc(bus.wr_count);
      end
   end

endmodule
